// File: rtl/com_bank.sv
`timescale 1ns/1ps
// com_bank: UART (8N1) host link to NCH write registers and NCH monitored inputs
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   rx         serial input, idle high, asynchronous to clk
//   tx         serial output, idle high
//   data_in    host-written registers, channel k at [k*WIDTH +: WIDTH]
//   data_out   device values reported to the host, same packing
//   wr_strobe  one-cycle pulse on the channel just written
module com_bank #(
  parameter int NCH          = 8,
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  output logic [NCH*WIDTH-1:0] data_in,
  input  logic [NCH*WIDTH-1:0] data_out,
  output logic [NCH-1:0]       wr_strobe
);
  localparam int ND = WIDTH / 4;
  localparam int CNTW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] HALF = CNTW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
  typedef enum logic [1:0] {P_IDLE, P_W_CH, P_W_DATA, P_R_CH} p_st_t;

  logic rx_m, rx_s, rx_p;
  rx_st_t rx_st, rx_st_n;
  logic [CNTW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_sh, rx_sh_n;
  logic rx_vld, rx_vld_n;

  // rx_p lags rx_s so a start needs a high-to-low transition; after a framing
  // error the line must therefore return high before the next frame is seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
      rx_st <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_vld <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_p <= rx_s;
      rx_st <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh <= rx_sh_n;
      rx_vld <= rx_vld_n;
    end
  end

  always_comb begin
    rx_st_n = rx_st;
    rx_cnt_n = rx_cnt + 1'b1;
    rx_bit_n = rx_bit;
    rx_sh_n = rx_sh;
    rx_vld_n = 1'b0;
    case (rx_st)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_p && !rx_s) rx_st_n = RX_START;
      end
      RX_START: if (rx_cnt == HALF) begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        rx_st_n = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt == FULL) begin
        rx_cnt_n = '0;
        rx_sh_n = {rx_s, rx_sh[7:1]};
        rx_bit_n = rx_bit + 1'b1;
        if (rx_bit == 3'd7) rx_st_n = RX_STOP;
      end
      RX_STOP: if (rx_cnt == FULL) begin
        rx_cnt_n = '0;
        rx_vld_n = rx_s;
        rx_st_n = RX_IDLE;
      end
      default: rx_st_n = RX_IDLE;
    endcase
  end

  logic is_dig, is_hex, ch_ok;
  logic [3:0] nib;
  assign is_dig = rx_sh >= "0" && rx_sh <= "9";
  assign is_hex = is_dig || (rx_sh >= "A" && rx_sh <= "F") || (rx_sh >= "a" && rx_sh <= "f");
  assign nib = is_dig ? rx_sh[3:0] : rx_sh[3:0] + 4'd9;
  assign ch_ok = is_hex && ({1'b0, nib} < 5'(NCH));

  p_st_t p_st, p_st_n;
  logic [3:0] p_ch, p_ch_n, dcnt, dcnt_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic commit, rd_req, err_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_st <= P_IDLE;
      p_ch <= '0;
      dcnt <= '0;
      acc <= '0;
      data_in <= '0;
      wr_strobe <= '0;
    end else begin
      p_st <= p_st_n;
      p_ch <= p_ch_n;
      dcnt <= dcnt_n;
      acc <= acc_n;
      wr_strobe <= commit ? NCH'(1) << p_ch : '0;
      if (commit) data_in[p_ch*WIDTH +: WIDTH] <= acc_n;
    end
  end

  always_comb begin
    p_st_n = p_st;
    p_ch_n = p_ch;
    dcnt_n = dcnt;
    acc_n = acc;
    commit = 1'b0;
    rd_req = 1'b0;
    err_req = 1'b0;
    if (rx_vld) begin
      case (p_st)
        P_IDLE: begin
          if (rx_sh == "S" || rx_sh == "s") p_st_n = P_W_CH;
          else if (rx_sh == "R" || rx_sh == "r") p_st_n = P_R_CH;
          else err_req = !(rx_sh == 8'h0d || rx_sh == 8'h0a || rx_sh == " ");
        end
        P_W_CH: begin
          p_ch_n = nib;
          acc_n = '0;
          dcnt_n = '0;
          p_st_n = ch_ok ? P_W_DATA : P_IDLE;
          err_req = !ch_ok;
        end
        P_W_DATA: begin
          acc_n = (acc << 4) | WIDTH'(nib);
          dcnt_n = dcnt + 1'b1;
          commit = is_hex && dcnt == 4'(ND - 1);
          p_st_n = (is_hex && !commit) ? P_W_DATA : P_IDLE;
          err_req = !is_hex;
        end
        P_R_CH: begin
          rd_req = ch_ok;
          err_req = !ch_ok;
          p_st_n = P_IDLE;
        end
        default: p_st_n = P_IDLE;
      endcase
    end
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // character i of the current message; value digits are taken MSB first
  function automatic logic [7:0] msg_char(input logic err, input logic [3:0] c,
                                          input logic [WIDTH-1:0] v, input logic [3:0] i);
    logic [3:0] d;
    d = 4'(v >> (4 * (ND + 1 - int'(i))));
    if (err) return i == 4'd0 ? 8'h3f : 8'h0a;
    return i == 4'd0 ? 8'h44 : i == 4'd1 ? hexc(c) : i == 4'(ND + 2) ? 8'h0a : hexc(d);
  endfunction

  logic [NCH*WIDTH-1:0] shadow;
  logic any;
  logic [3:0] low;

  always_comb begin
    any = 1'b0;
    low = '0;
    for (int k = NCH - 1; k >= 0; k--)
      if (data_out[k*WIDTH +: WIDTH] != shadow[k*WIDTH +: WIDTH]) begin
        any = 1'b1;
        low = 4'(k);
      end
  end

  logic busy, m_err, slot_v, slot_err;
  logic [3:0] m_ch, idx, bcnt, slot_ch, last;
  logic [WIDTH-1:0] m_val;
  logic [9:0] frame;
  logic [CNTW-1:0] tcnt;
  logic [7:0] nxt;

  assign last = m_err ? 4'd1 : 4'(ND + 2);
  assign nxt = msg_char(m_err, m_ch, m_val, idx + 4'd1);
  assign tx = ~busy | frame[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      m_err <= 1'b0;
      m_ch <= '0;
      m_val <= '0;
      idx <= '0;
      bcnt <= '0;
      tcnt <= '0;
      frame <= '1;
      shadow <= '0;
      slot_v <= 1'b0;
      slot_err <= 1'b0;
      slot_ch <= '0;
    end else begin
      if (!busy) begin
        if (slot_v || any) begin
          busy <= 1'b1;
          bcnt <= '0;
          tcnt <= '0;
          idx <= '0;
          m_err <= slot_v && slot_err;
          m_ch <= slot_v ? slot_ch : low;
          m_val <= slot_v ? data_in[slot_ch*WIDTH +: WIDTH] : data_out[low*WIDTH +: WIDTH];
          frame <= {1'b1, (slot_v && slot_err) ? 8'h3f : 8'h44, 1'b0};
          slot_v <= 1'b0;
          // the reported snapshot becomes the new reference for change detection
          if (!slot_v) shadow[low*WIDTH +: WIDTH] <= data_out[low*WIDTH +: WIDTH];
        end
      end else if (tcnt != FULL) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= '0;
        if (bcnt != 4'd9) begin
          bcnt <= bcnt + 1'b1;
          frame <= {1'b1, frame[9:1]};
        end else if (idx == last) begin
          busy <= 1'b0;
        end else begin
          bcnt <= '0;
          idx <= idx + 1'b1;
          frame <= {1'b1, nxt, 1'b0};
        end
      end
      // a fresh request replaces any entry not yet taken by the transmitter
      if (rd_req || err_req) begin
        slot_v <= 1'b1;
        slot_err <= err_req;
        slot_ch <= nib;
      end
    end
  end
endmodule

// File: tb/tb_com_bank.sv
`timescale 1ns/1ps
// tb_com_bank: directed self-checking bench for com_bank (NCH=8, WIDTH=8, 104 clocks/bit)
module tb_com_bank;
  localparam int NCH = 8;
  localparam int WIDTH = 8;
  localparam int CPB = 104;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic tx;
  logic [NCH*WIDTH-1:0] data_in;
  logic [NCH*WIDTH-1:0] data_out = '0;
  logic [NCH-1:0] wr_strobe;

  com_bank #(.NCH(NCH), .WIDTH(WIDTH), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx),
    .data_in(data_in), .data_out(data_out), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  longint cyc = 0;
  int stb [NCH] = '{default: 0};

  typedef struct {
    logic [7:0] b;
    longint t;
    logic stop;
  } ch_t;
  ch_t q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < NCH; k++) if (wr_strobe[k]) stb[k] <= stb[k] + 1;
  end

  // serial receiver watching tx: records each character, its stop bit and start cycle
  initial forever begin
    @(negedge clk);
    if (tx === 1'b0) begin
      ch_t c;
      c.t = cyc;
      c.b = '0;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        c.b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      c.stop = tx;
      q.push_back(c);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic expect_msg(input string s, input string tag);
    int w;
    ch_t c;
    longint pt;
    w = 0;
    pt = 0;
    while (q.size() < s.len() && w < 30000) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_len"}, 64'(q.size() >= s.len() ? s.len() : q.size()), 64'(s.len()));
    if (q.size() >= s.len()) begin
      for (int i = 0; i < s.len(); i++) begin
        c = q.pop_front();
        chk($sformatf("%s_char%0d", tag, i), c.b, s[i]);
        chk($sformatf("%s_stop%0d", tag, i), c.stop, 1);
        if (i > 0) chk($sformatf("%s_gap%0d", tag, i), c.t - pt, 10 * CPB);
        pt = c.t;
      end
    end
  endtask

  initial begin
    int w;
    repeat (5) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_data_in", data_in, 0);
    chk("rst_strobe", wr_strobe, 0);
    rst_n = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    chk("idle_q", q.size(), 0);
    chk("idle_tx", tx, 1);
    chk("idle_data_in", data_in, 0);
    chk("idle_strobes", stb.sum(), 0);

    send_str("S0E6");
    repeat (10) @(negedge clk);
    chk("w0_val", data_in, 64'h0000_0000_0000_00E6);
    chk("w0_stb", stb[0], 1);
    send_str("s6d4");
    repeat (10) @(negedge clk);
    chk("w6_val", data_in, 64'h00D4_0000_0000_00E6);
    chk("w6_stb", stb[6], 1);
    chk("w_stb_total", stb.sum(), 2);
    chk("w_no_tx", q.size(), 0);

    data_out[7:0] = 8'h9B;
    repeat (200) @(negedge clk);
    data_out[47:40] = 8'hAA;
    send_str("R0");
    expect_msg("D09B\n", "rep0");
    expect_msg("D0E6\n", "rd0");
    expect_msg("D5AA\n", "rep5");
    repeat (1500) @(negedge clk);
    chk("stable_q", q.size(), 0);
    chk("stable_tx", tx, 1);

    send_str("R6");
    expect_msg("D6D4\n", "rd6");
    send_str("S9");
    expect_msg("?\n", "bad_ch");
    send_str("S0G");
    expect_msg("?\n", "bad_hex");
    chk("bad_hex_keep", data_in[7:0], 8'hE6);
    chk("bad_hex_stb", stb[0], 1);

    send_byte("S", 1'b0);
    repeat (CPB) @(negedge clk);
    send_str("S13C");
    repeat (1500) @(negedge clk);
    chk("frm_q", q.size(), 0);
    chk("frm_val", data_in, 64'h00D4_0000_0000_3CE6);
    chk("frm_stb", stb[1], 1);

    data_out[7:0] = 8'h00;
    w = 0;
    while (q.size() < 1 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("pre_rst_len", q.size(), 1);
    repeat (300) @(negedge clk);
    chk("pre_rst_tx", tx, 0);
    #1 rst_n = 1'b0;
    #1 chk("mid_rst_tx", tx, 1);
    chk("mid_rst_data_in", data_in, 0);
    chk("mid_rst_strobe", wr_strobe, 0);
    repeat (1200) @(negedge clk);
    q.delete();
    rst_n = 1'b1;
    expect_msg("D5AA\n", "post_rst");
    repeat (1500) @(negedge clk);
    chk("post_rst_q", q.size(), 0);
    chk("post_rst_data_in", data_in, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
